bn_param_loader: RTL and testbench
==================================

BN_PARAM_LOADER -- requirements
Module: bn_param_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 2: neuron index width; the bank holds NEURONS = 2**ADDR_WIDTH entries.
REQ-002 Parameter ADDEND_WIDTH, default 5: signed BN addend width.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port cfg_start, input, 1: one-cycle pulse that opens a configuration frame.
REQ-006 Port cfg_valid, input, 1: cfg_data carries a frame bit in this cycle.
REQ-007 Port cfg_data, input, 1: serial frame bit, MSB first.
REQ-008 Port sel, input, ADDR_WIDTH: neuron index for the read port.
REQ-009 Port BN_factor, output, 4: factor code of entry sel.
REQ-010 Port BN_addend, output signed, ADDEND_WIDTH: addend of entry sel.
REQ-011 Port busy, output, 1: high whenever the FSM is not IDLE.
REQ-012 Port load_done, output, 1: one-cycle pulse, entry written.
REQ-013 Port load_error, output, 1: one-cycle pulse, frame rejected.

Function
REQ-014 Frame = {addr[ADDR_WIDTH], factor[4], addend[ADDEND_WIDTH]}, MSB first; FRAME_BITS = ADDR_WIDTH+4+ADDEND_WIDTH (11 at defaults).
REQ-015 FSM states: IDLE, SHIFT, COMMIT.
REQ-016 IDLE -> SHIFT on cfg_start; the shift register and bit counter clear to 0.
REQ-017 In SHIFT, each cycle with cfg_valid=1 shifts cfg_data in at the LSB and increments the counter; cycles with cfg_valid=0 leave state and counter unchanged.
REQ-018 The edge that accepts bit FRAME_BITS-1 moves SHIFT -> COMMIT.
REQ-019 cfg_start in SHIFT restarts the frame: counter and shift register clear, state stays SHIFT, and no done or error pulse is issued.
REQ-020 In IDLE and COMMIT, cfg_valid is ignored. cfg_start in COMMIT is ignored.
REQ-021 COMMIT lasts exactly one cycle and always returns to IDLE.
- Valid frame: bank[addr] is written at the COMMIT-exit edge, and load_done is high for the following cycle.
- Invalid frame: the bank is unchanged, and load_error is high for the following cycle.
REQ-022 Invalid factor codes: 0000, 0111, 1011, 1111.
REQ-023 Factor 0011 (x8) with a nonzero addend is invalid.
REQ-024 BN_factor and BN_addend are combinational reads of bank[sel]; a written value is visible in the same cycle load_done is high.
REQ-025 load_done and load_error are never high in the same cycle.
REQ-026 Minimum frame-to-frame period: FRAME_BITS+2 cycles (start, bits, commit).

Reset
REQ-027 rst_n=0 immediately forces:
- FSM to IDLE; counter and shift register to 0;
- busy=0, load_done=0, load_error=0;
- every bank entry to factor 4'b0100 (x1) and addend 0.
REQ-028 Reset asserted mid-frame discards the partial frame; no entry is modified.
REQ-029 Deassertion is used as-is; synchronising it is outside this block.

Configuration
REQ-030 Macro BN_PARAM_CHECK_EN:
- Defined: REQ-022 and REQ-023 validation is applied.
- Undefined: every frame is treated as valid and written, and load_error is tied to 0.

Verification
REQ-031 Reset, then sweep sel 0..3 -> BN_factor=0100 and BN_addend=0 for every entry; busy=0.
REQ-032 Frame addr=2, factor=0101, addend=-3, with no gaps -> busy for 12 cycles; load_done pulses once; sel=2 reads 0101/-3; entries 0, 1, 3 unchanged.
REQ-033 Frame addr=1, factor=0111 (check enabled) -> load_error pulses once and entry 1 stays 0100/0. With the macro undefined -> load_done pulses and entry 1 reads 0111.
REQ-034 Frame addr=3, factor=0011, addend=+1 -> load_error. Same frame with addend=0 -> load_done and entry 3 reads 0011/0.
REQ-035 Send 6 bits, pulse cfg_start, then send a full frame addr=0, factor=1100, addend=2 with cfg_valid low on alternate cycles -> exactly one load_done; entry 0 reads 1100/2.
REQ-036 Pull rst_n low after 7 bits of a frame -> busy=0 at once; no done or error pulse; all entries at reset values.

Source files
------------

// File: rtl/bn_param_loader.sv
// Batch-norm parameter bank, loaded over a serial frame {addr, factor, addend}, MSB first.
// Define BN_PARAM_CHECK_EN to reject illegal factor codes and nonzero x8 addends.
module bn_param_loader #(
  parameter int ADDR_WIDTH   = 2,
  parameter int ADDEND_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_start,
  input  logic                           cfg_valid,
  input  logic                           cfg_data,
  input  logic [ADDR_WIDTH-1:0]          sel,
  output logic [3:0]                     BN_factor,
  output logic signed [ADDEND_WIDTH-1:0] BN_addend,
  output logic                           busy,
  output logic                           load_done,
  output logic                           load_error
);

  localparam int NEURONS    = 2 ** ADDR_WIDTH;
  localparam int FRAME_BITS = ADDR_WIDTH + 4 + ADDEND_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);
  localparam logic [3:0]       FACTOR_RESET = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  state_t                        state_q;
  logic [FRAME_BITS-1:0]         shift_q;
  logic [CNT_W-1:0]              cnt_q;

  logic [3:0]                    factor_mem [NEURONS];
  logic signed [ADDEND_WIDTH-1:0] addend_mem [NEURONS];

  logic [ADDR_WIDTH-1:0]          frame_addr;
  logic [3:0]                     frame_factor;
  logic signed [ADDEND_WIDTH-1:0] frame_addend;
  logic                           frame_ok;
  logic                           commit_write;

  assign frame_addr   = shift_q[FRAME_BITS-1 -: ADDR_WIDTH];
  assign frame_factor = shift_q[ADDEND_WIDTH +: 4];
  assign frame_addend = shift_q[ADDEND_WIDTH-1:0];

`ifdef BN_PARAM_CHECK_EN
  always_comb begin
    // NOTE: default first so every path assigns frame_ok and no latch is inferred.
    frame_ok = 1'b1;
    if (frame_factor inside {4'b0000, 4'b0111, 4'b1011, 4'b1111})
      frame_ok = 1'b0;
    // x8 scaling only supports a zero addend.
    if (frame_factor == 4'b0011 && frame_addend != '0)
      frame_ok = 1'b0;
  end
`else
  assign frame_ok   = 1'b1;
  assign load_error = 1'b0;
`endif

  assign commit_write = (state_q == COMMIT) && frame_ok;
  assign busy         = (state_q != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      load_done  <= 1'b0;
`ifdef BN_PARAM_CHECK_EN
      load_error <= 1'b0;
`endif
    end else begin
      load_done  <= 1'b0;
`ifdef BN_PARAM_CHECK_EN
      load_error <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          // A new start abandons the partial frame without any status pulse.
          if (cfg_start) begin
            shift_q <= '0;
            cnt_q   <= '0;
          end else if (cfg_valid) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], cfg_data};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT)
              state_q <= COMMIT;
          end
        end
        COMMIT: begin
          state_q    <= IDLE;
          load_done  <= frame_ok;
`ifdef BN_PARAM_CHECK_EN
          load_error <= !frame_ok;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the bank is flop-based and reset explicitly, since every entry must read x1/0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEURONS; i++) begin
        factor_mem[i] <= FACTOR_RESET;
        addend_mem[i] <= '0;
      end
    end else if (commit_write) begin
      factor_mem[frame_addr] <= frame_factor;
      addend_mem[frame_addr] <= frame_addend;
    end
  end

  assign BN_factor = factor_mem[sel];
  assign BN_addend = addend_mem[sel];

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed self-checking bench for bn_param_loader; expectations follow BN_PARAM_CHECK_EN when defined.
module tb_bn_param_loader;

  localparam int AW = 2;
  localparam int DW = 5;
  localparam int FB = AW + 4 + DW;
  localparam int N  = 2 ** AW;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 cfg_start = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_data  = 1'b0;
  logic [AW-1:0]        sel       = '0;
  logic [3:0]           BN_factor;
  logic signed [DW-1:0] BN_addend;
  logic                 busy;
  logic                 load_done;
  logic                 load_error;

  int errors = 0;
  int checks = 0;

  int mon_busy, mon_done, mon_err, mon_both;
  logic [AW-1:0]        cap_addr;
  logic [3:0]           cap_factor;
  logic signed [DW-1:0] cap_addend;

  logic [3:0]           exp_factor [N];
  logic signed [DW-1:0] exp_addend [N];
  logic [3:0]           rd_f;
  logic signed [DW-1:0] rd_a;

  bn_param_loader #(.ADDR_WIDTH(AW), .ADDEND_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .sel        (sel),
    .BN_factor  (BN_factor),
    .BN_addend  (BN_addend),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // One clock, then sample outputs 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) mon_busy++;
    if (load_error) mon_err++;
    if (load_done && load_error) mon_both++;
    if (load_done) begin
      mon_done++;
      sel = cap_addr;
      #1;
      cap_factor = BN_factor;
      cap_addend = BN_addend;
    end
  endtask

  task automatic clear_mon();
    mon_busy = 0;
    mon_done = 0;
    mon_err  = 0;
    mon_both = 0;
    cap_factor = 'x;
    cap_addend = 'x;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bits(input logic [FB-1:0] fr, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = fr[FB-1-i];
      tick();
      if (gaps) begin
        cfg_valid = 1'b0;
        cfg_data  = ~cfg_data;
        tick();
      end
    end
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
  endtask

  task automatic wait_idle(input int tail);
    for (int i = 0; i < 30 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    for (int i = 0; i < tail; i++) tick();
  endtask

  task automatic do_frame(input logic [AW-1:0] a, input logic [3:0] f,
                          input logic signed [DW-1:0] d, input bit gaps);
    clear_mon();
    cap_addr = a;
    pulse_start();
    send_bits({a, f, d}, FB, gaps);
    wait_idle(2);
  endtask

  task automatic read_entry(input int idx);
    sel = AW'(idx);
    #1;
    rd_f = BN_factor;
    rd_a = BN_addend;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      exp_factor[i] = 4'b0100;
      exp_addend[i] = '0;
    end
    #12;
    checks++;
    if ({busy, load_done, load_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: busy/done/err=%b required 000", {busy, load_done, load_error});
    end
    for (int i = 0; i < N; i++) begin
      read_entry(i);
      checks++;
      if (rd_f !== 4'b0100 || rd_a !== 5'sd0) begin
        errors++;
        $display("FAIL reset_entry%0d: got %b/%0d required 0100/0", i, rd_f, rd_a);
      end
    end
    rst_n = 1'b1;
    clear_mon();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_frame();
    do_frame(2'd2, 4'b0101, -5'sd3, 1'b0);
    exp_factor[2] = 4'b0101;
    exp_addend[2] = -5'sd3;
    checks++;
    if (mon_busy !== 12) begin
      errors++;
      $display("FAIL single_busy_cycles: got %0d required 12", mon_busy);
    end
    checks++;
    if (mon_done !== 1 || mon_err !== 0) begin
      errors++;
      $display("FAIL single_pulses: done=%0d err=%0d required 1/0", mon_done, mon_err);
    end
    checks++;
    if (cap_factor !== 4'b0101 || cap_addend !== -5'sd3) begin
      errors++;
      $display("FAIL single_same_cycle: got %b/%0d required 0101/-3", cap_factor, cap_addend);
    end
    for (int i = 0; i < N; i++) begin
      read_entry(i);
      checks++;
      if (rd_f !== exp_factor[i] || rd_a !== exp_addend[i]) begin
        errors++;
        $display("FAIL single_entry%0d: got %b/%0d required %b/%0d", i, rd_f, rd_a, exp_factor[i], exp_addend[i]);
      end
    end
  endtask

  task automatic test_bad_factor();
    int exp_done, exp_err;
    do_frame(2'd1, 4'b0111, 5'sd0, 1'b0);
`ifdef BN_PARAM_CHECK_EN
    exp_done = 0;
    exp_err  = 1;
`else
    exp_done = 1;
    exp_err  = 0;
    exp_factor[1] = 4'b0111;
    exp_addend[1] = 5'sd0;
`endif
    checks++;
    if (mon_done !== exp_done || mon_err !== exp_err || mon_both !== 0) begin
      errors++;
      $display("FAIL bad_factor_pulses: done=%0d err=%0d both=%0d required %0d/%0d/0",
               mon_done, mon_err, mon_both, exp_done, exp_err);
    end
    read_entry(1);
    checks++;
    if (rd_f !== exp_factor[1] || rd_a !== exp_addend[1]) begin
      errors++;
      $display("FAIL bad_factor_entry1: got %b/%0d required %b/%0d", rd_f, rd_a, exp_factor[1], exp_addend[1]);
    end
  endtask

  task automatic test_x8_addend();
    int exp_done, exp_err;
    do_frame(2'd3, 4'b0011, 5'sd1, 1'b0);
`ifdef BN_PARAM_CHECK_EN
    exp_done = 0;
    exp_err  = 1;
`else
    exp_done = 1;
    exp_err  = 0;
    exp_factor[3] = 4'b0011;
    exp_addend[3] = 5'sd1;
`endif
    checks++;
    if (mon_done !== exp_done || mon_err !== exp_err) begin
      errors++;
      $display("FAIL x8_nonzero_pulses: done=%0d err=%0d required %0d/%0d", mon_done, mon_err, exp_done, exp_err);
    end
    read_entry(3);
    checks++;
    if (rd_f !== exp_factor[3] || rd_a !== exp_addend[3]) begin
      errors++;
      $display("FAIL x8_nonzero_entry3: got %b/%0d required %b/%0d", rd_f, rd_a, exp_factor[3], exp_addend[3]);
    end
    do_frame(2'd3, 4'b0011, 5'sd0, 1'b0);
    exp_factor[3] = 4'b0011;
    exp_addend[3] = 5'sd0;
    checks++;
    if (mon_done !== 1 || mon_err !== 0) begin
      errors++;
      $display("FAIL x8_zero_pulses: done=%0d err=%0d required 1/0", mon_done, mon_err);
    end
    read_entry(3);
    checks++;
    if (rd_f !== 4'b0011 || rd_a !== 5'sd0) begin
      errors++;
      $display("FAIL x8_zero_entry3: got %b/%0d required 0011/0", rd_f, rd_a);
    end
  endtask

  task automatic test_restart_gaps();
    clear_mon();
    cap_addr = 2'd0;
    pulse_start();
    send_bits({FB{1'b1}}, 6, 1'b0);
    pulse_start();
    send_bits({2'd0, 4'b1100, 5'sd2}, FB, 1'b1);
    wait_idle(2);
    exp_factor[0] = 4'b1100;
    exp_addend[0] = 5'sd2;
    checks++;
    if (mon_done !== 1 || mon_err !== 0) begin
      errors++;
      $display("FAIL restart_pulses: done=%0d err=%0d required 1/0", mon_done, mon_err);
    end
    for (int i = 0; i < N; i++) begin
      read_entry(i);
      checks++;
      if (rd_f !== exp_factor[i] || rd_a !== exp_addend[i]) begin
        errors++;
        $display("FAIL restart_entry%0d: got %b/%0d required %b/%0d", i, rd_f, rd_a, exp_factor[i], exp_addend[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    cap_addr = 2'd1;
    pulse_start();
    send_bits({2'd1, 4'b1000, -5'sd16}, FB, 1'b0);
    // Now in COMMIT: a start here must be ignored.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b0 || mon_done !== 1) begin
      errors++;
      $display("FAIL b2b_commit_start: busy=%b done=%0d required 0/1", busy, mon_done);
    end
    checks++;
    if (cap_factor !== 4'b1000 || cap_addend !== -5'sd16) begin
      errors++;
      $display("FAIL b2b_first: got %b/%0d required 1000/-16", cap_factor, cap_addend);
    end
    cap_addr = 2'd3;
    pulse_start();
    send_bits({2'd3, 4'b0010, 5'sd15}, FB, 1'b0);
    wait_idle(2);
    exp_factor[1] = 4'b1000;
    exp_addend[1] = -5'sd16;
    exp_factor[3] = 4'b0010;
    exp_addend[3] = 5'sd15;
    checks++;
    if (mon_done !== 2 || mon_err !== 0) begin
      errors++;
      $display("FAIL b2b_pulses: done=%0d err=%0d required 2/0", mon_done, mon_err);
    end
    for (int i = 0; i < N; i++) begin
      read_entry(i);
      checks++;
      if (rd_f !== exp_factor[i] || rd_a !== exp_addend[i]) begin
        errors++;
        $display("FAIL b2b_entry%0d: got %b/%0d required %b/%0d", i, rd_f, rd_a, exp_factor[i], exp_addend[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    cap_addr = 2'd2;
    pulse_start();
    send_bits({2'd2, 4'b0110, 5'sd5}, 7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, load_done, load_error} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_outputs: busy/done/err=%b required 000", {busy, load_done, load_error});
    end
    #3;
    rst_n = 1'b1;
    clear_mon();
    send_bits({2'd2, 4'b0110, 5'sd5}, 4, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < N; i++) begin
      exp_factor[i] = 4'b0100;
      exp_addend[i] = '0;
    end
    checks++;
    if (mon_done !== 0 || mon_err !== 0 || mon_busy !== 0) begin
      errors++;
      $display("FAIL midreset_pulses: done=%0d err=%0d busy=%0d required 0/0/0", mon_done, mon_err, mon_busy);
    end
    for (int i = 0; i < N; i++) begin
      read_entry(i);
      checks++;
      if (rd_f !== exp_factor[i] || rd_a !== exp_addend[i]) begin
        errors++;
        $display("FAIL midreset_entry%0d: got %b/%0d required %b/%0d", i, rd_f, rd_a, exp_factor[i], exp_addend[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_factor();
    test_x8_addend();
    test_restart_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
